microsequencer: RTL and testbench
=================================

# microsequencer

Microprogram sequencer for the control-memory datapath. It owns the micro-program counter (uPC) and drives the 5-bit address into the 23-bit control ROM. It splits each returned microword into a branch part and a 15-bit control field, and it chooses the next address from datapath condition flags. It also provides the start/busy/done handshake to the host and flags any branch out of the populated ROM range.

## Interface
Parameters:
- AW, 5: ROM address width.
- CW, 15: control-field width (microword bits [CW-1:0]).
- SW, 3: branch-select width (microword bits [22:20]).
- DEPTH, 18: populated ROM words; the legal address range is 0..DEPTH-1.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high; one clock, reset asynchronous active-high.
- start  in  1  request to run the microprogram from address 0.
- cond  in  7  datapath condition flags, sampled combinationally every RUN cycle.
- data  in  23  microword from ROM. Fields:
  - [22:20] sel, branch select.
  - [19:15] baddr, branch target.
  - [14:0] control field.
- addr  out  AW  ROM address; equals uPC.
- ctrl  out  CW  active control field, driven to datapath.
- busy  out  1  high while in RUN.
- done  out  1  high while in DONE.
- err  out  1  sticky range error.
- cycles  out  8  RUN-cycle count of the current or last run; saturates at 255.

## Operation
- States: IDLE, RUN, DONE. The reset state is IDLE.
- Next-address rule, applied in RUN only:
  - sel==0: next = baddr (unconditional jump).
  - sel==k, for k in 1..7: next = cond[k-1] ? baddr : uPC+1.
  - uPC+1 is computed at AW+1 bits. 31+1 gives 32, which is an error, not a wrap to 0.
- IDLE:
  - uPC = 0, so addr = 0.
  - ctrl = 0, busy = 0, done = 0.
  - start=1 moves to RUN with uPC=0, clears err, and clears cycles to 0.
- RUN:
  - ctrl = data[14:0] combinationally.
  - busy = 1.
  - cycles increments by 1 each cycle, saturating at 255.
  - Evaluate next at each clock edge, in this priority order:
    1. next >= DEPTH: go to IDLE, set err=1, uPC=0.
    2. next == uPC (taken self-loop = halt): go to DONE; uPC holds.
    3. Otherwise: uPC <= next.
- DONE:
  - ctrl = 0, done = 1.
  - addr holds the halt address.
  - start=1 moves to RUN with uPC=0, clears cycles to 0, and clears err.
  - start=0 stays in DONE.
- start is ignored while in RUN. There is no restart mid-program.
- The ROM is treated as purely combinational: data is valid in the same cycle as addr.

## Timing
- Reset values: addr=0, ctrl=0, busy=0, done=0, err=0, cycles=0, state=IDLE.
- Reset asserted mid-RUN: all outputs return to their reset values immediately (asynchronous), independent of clk.
- Start latency:
  - start sampled high at edge N gives busy=1 and addr=0 after edge N.
  - The word at address 0 drives ctrl during cycle N+1.
- Each microinstruction occupies exactly one clock cycle.
- The halt word is active for exactly one RUN cycle; done rises at the following edge.
- cycles counts RUN cycles, including the halt cycle.
- A range error is detected in the cycle whose computed next is out of range:
  - err=1 and busy=0 after that edge.
  - err stays high until the next accepted start.
- If start is high in the same cycle as the halt is detected, start is ignored and DONE is entered.

## Test plan
- Reset mid-run: at the cycle where addr=5, assert reset asynchronously. Check that addr=0, busy=0, and ctrl=0 before the next clk edge, and that state is IDLE.
- Sequential walk with the team ROM loaded (words 0..17), cond=0, pulse start:
  - addr runs 0,1,2,…,17 on consecutive cycles.
  - ctrl equals each word's bits [14:0].
  - At addr=17 (sel=4, cond[3]=0), next=18 is out of range: err=1, busy=0, cycles=18.
- Halt, same ROM:
  - cond=0, except cond[3] forced to 1 when addr=17.
  - Expect done=1 one edge later, addr held at 17, ctrl=0, cycles=18.
- Taken branch, same ROM:
  - Set cond[0]=1 only while addr=3 (sel=1, baddr=12).
  - Expect the next addr to be 12, then 13.
  - With cond[1]=1 at addr=12 (sel=2, baddr=14), expect 14 next.
- Loop-back:
  - Set cond[3]=1 at addr=11 (sel=4, baddr=3); addr returns to 3.
  - Set cond[3]=1 at addr=8; addr jumps to 10.
  - cycles keeps counting across the loop.
- Handshake:
  - start held high throughout RUN causes no restart.
  - start in DONE restarts at addr=0 with cycles=0.
  - Run a long loop past 255 RUN cycles: cycles saturates at 255.

Source files
------------

// File: rtl/microsequencer.sv
// Microprogram sequencer: owns the uPC, addresses a combinational control
// ROM, splits each microword into branch select/target and control field,
// and runs a start/busy/done handshake with a sticky out-of-range flag.
module microsequencer #(
   parameter int AW    = 5,
   parameter int CW    = 15,
   parameter int SW    = 3,
   parameter int DEPTH = 18
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [(2**SW)-2:0]    cond,
   input  logic [SW+AW+CW-1:0]   data,
   output logic [AW-1:0]         addr,
   output logic [CW-1:0]         ctrl,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [7:0]            cycles
);

   // Legal-range limit at the widened next-address width, so uPC+1 from the
   // top address shows up as out of range instead of wrapping to 0.
   localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state, state_nx;
   logic [AW-1:0]   upc, upc_nx;
   logic            err_flag, err_nx;
   logic [7:0]      cnt, cnt_nx;

   logic [SW-1:0]   sel;
   logic [AW-1:0]   baddr;
   logic [2**SW-1:0] cond_ext;
   logic            taken;
   logic [AW:0]     upc_inc;
   logic [AW:0]     target;
   logic            out_of_range;
   logic            halt;
   logic [7:0]      cnt_sat;

   assign sel   = data[CW+AW +: SW];
   assign baddr = data[CW +: AW];

   // Bit 0 is a constant 1 so that sel==0 selects an unconditional jump and
   // sel==k selects cond[k-1] without any subtraction.
   assign cond_ext     = {cond, 1'b1};
   assign taken        = cond_ext[sel];
   assign upc_inc      = {1'b0, upc} + (AW+1)'(1);
   assign target       = taken ? {1'b0, baddr} : upc_inc;
   assign out_of_range = (target >= LIMIT);
   assign halt         = (target == {1'b0, upc});
   assign cnt_sat      = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

   // State, uPC, error flag and cycle counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         upc      <= '0;
         err_flag <= 1'b0;
         cnt      <= 8'd0;
      end else begin
         state    <= state_nx;
         upc      <= upc_nx;
         err_flag <= err_nx;
         cnt      <= cnt_nx;
      end
   end

   // Next-state and next-uPC selection; range error beats halt beats advance.
   always_comb begin
      state_nx = state;
      upc_nx   = upc;
      err_nx   = err_flag;
      cnt_nx   = cnt;
      case (state)
         IDLE, DONE: begin
            if (state == IDLE) begin
               upc_nx = '0;
            end
            if (start) begin
               state_nx = RUN;
               upc_nx   = '0;
               err_nx   = 1'b0;
               cnt_nx   = 8'd0;
            end
         end
         RUN: begin
            cnt_nx = cnt_sat;
            if (out_of_range) begin
               state_nx = IDLE;
               err_nx   = 1'b1;
               upc_nx   = '0;
            end else if (halt) begin
               state_nx = DONE;
            end else begin
               upc_nx = target[AW-1:0];
            end
         end
         default: begin
            state_nx = IDLE;
            upc_nx   = '0;
         end
      endcase
   end

   // Handshake and control-field outputs decoded from the current state.
   always_comb begin
      ctrl = '0;
      busy = 1'b0;
      done = 1'b0;
      case (state)
         RUN: begin
            ctrl = data[CW-1:0];
            busy = 1'b1;
         end
         DONE: begin
            done = 1'b1;
         end
         default: begin
            ctrl = '0;
         end
      endcase
   end

   assign addr   = upc;
   assign err    = err_flag;
   assign cycles = cnt;

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench for microsequencer: behavioural model plus per-cycle
// compare, directed program scenarios and a randomized phase.
module tb_microsequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic [6:0]  cond;
   logic [22:0] data;
   logic [4:0]  addr;
   logic [14:0] ctrl;
   logic        busy, done, err;
   logic [7:0]  cycles;

   logic [22:0] rom [0:31];

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 0;
   int trace [0:63];

   // model: mode 0 idle, 1 run, 2 done
   int m_mode, m_pc, m_cyc;
   bit m_err;

   microsequencer dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .cond  (cond),
      .data  (data),
      .addr  (addr),
      .ctrl  (ctrl),
      .busy  (busy),
      .done  (done),
      .err   (err),
      .cycles(cycles)
   );

   assign data = rom[addr];

   initial clk = 0;
   always #5 clk = ~clk;

   function automatic logic [22:0] mk(input int s, input int b, input int c);
      logic [2:0]  s3;
      logic [4:0]  b5;
      logic [14:0] c15;
      s3 = 3'(s); b5 = 5'(b); c15 = 15'(c);
      return {s3, b5, c15};
   endfunction

   // next address by the plain rule: jump if unconditional or flag set
   function automatic int next_of(input int pc, input logic [6:0] c);
      logic [22:0] w;
      int s, b;
      w = rom[pc];
      s = int'(w[22:20]);
      b = int'(w[19:15]);
      if (s == 0 || c[s-1]) return b;
      return pc + 1;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // behavioural reference model
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_mode <= 0; m_pc <= 0; m_err <= 0; m_cyc <= 0;
      end else if (m_mode == 1) begin
         m_cyc <= (m_cyc < 255) ? m_cyc + 1 : 255;
         if (next_of(m_pc, cond) >= 18) begin
            m_mode <= 0; m_err <= 1; m_pc <= 0;
         end else if (next_of(m_pc, cond) == m_pc) begin
            m_mode <= 2;
         end else begin
            m_pc <= next_of(m_pc, cond);
         end
      end else if (start) begin
         m_mode <= 1; m_pc <= 0; m_err <= 0; m_cyc <= 0;
      end
   end

   // per-cycle comparison against the model
   always @(negedge clk) begin
      if (cmp_en && !reset) begin
         check("addr", addr, m_pc);
         check("ctrl", ctrl, (m_mode == 1) ? {17'd0, rom[m_pc][14:0]} : 32'd0);
         check("busy", busy, m_mode == 1);
         check("done", done, m_mode == 2);
         check("err", err, m_err);
         check("cycles", cycles, m_cyc);
      end
   end

   function automatic logic [6:0] policy(input int mode, input int pc, input int loops);
      case (mode)
         1: return (pc == 17) ? 7'd8 : 7'd0;
         2: return (pc == 3) ? 7'd1 : 7'd0;
         3: return (pc == 3) ? 7'd1 : (pc == 12) ? 7'd2 : 7'd0;
         4: return ((pc == 11 && loops == 0) || (pc == 8 && loops == 1) || pc == 17) ? 7'd8 : 7'd0;
         5: return ((pc == 11 && loops < 40) || pc == 17) ? 7'd8 : 7'd0;
         default: return 7'd0;
      endcase
   endfunction

   task automatic finish_run(input int mode, input bit hold, output int n);
      int loops;
      loops = 0;
      n = 0;
      while (m_mode == 1 && n < 600) begin
         if (n < 64) trace[n] = int'(addr);
         cond = policy(mode, m_pc, loops);
         if (m_pc == 11) loops++;
         if (hold) start = 1;
         @(posedge clk); #1;
         n++;
      end
      start = 0;
      cond  = 0;
      if (m_mode == 1) check("run_timeout", 1, 0);
   endtask

   task automatic run_prog(input int mode, input bit hold, output int n);
      start = 1;
      @(posedge clk); #1;
      if (!hold) start = 0;
      check("lat_addr", addr, 0);
      check("lat_busy", busy, 1);
      check("lat_cycles", cycles, 0);
      check("lat_ctrl", ctrl, {17'd0, rom[0][14:0]});
      finish_run(mode, hold, n);
   endtask

   initial begin
      int n;
      for (int i = 0; i < 32; i++) rom[i] = '0;
      for (int i = 0; i < 18; i++) rom[i] = mk((i % 7) + 1, (i * 7 + 3) % 18, i * 2731 + 17);
      rom[3]  = mk(1, 12, 15'h0A33);
      rom[8]  = mk(4, 10, 15'h1808);
      rom[11] = mk(4, 3,  15'h2B11);
      rom[12] = mk(2, 14, 15'h3C12);
      rom[17] = mk(4, 17, 15'h7F17);

      reset = 1; start = 0; cond = 0;
      #12;
      check("rst_addr", addr, 0);
      check("rst_ctrl", ctrl, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_cycles", cycles, 0);
      @(negedge clk); reset = 0;
      @(posedge clk); #1;
      cmp_en = 1;

      // asynchronous reset in the middle of a run
      start = 1;
      @(posedge clk); #1;
      start = 0;
      for (int i = 0; i < 20 && m_pc != 5; i++) begin
         @(posedge clk); #1;
      end
      check("reach5", addr, 5);
      #2 reset = 1;
      #1;
      check("amid_addr", addr, 0);
      check("amid_busy", busy, 0);
      check("amid_ctrl", ctrl, 0);
      check("amid_done", done, 0);
      check("amid_cycles", cycles, 0);
      reset = 0;
      @(posedge clk); #1;

      // sequential walk ending in a range error
      run_prog(0, 0, n);
      check("walk_len", n, 18);
      for (int i = 0; i < 18; i++) check("walk_trace", trace[i], i);
      check("walk_err", err, 1);
      check("walk_busy", busy, 0);
      check("walk_cycles", cycles, 18);
      check("walk_addr", addr, 0);

      // halt at the last word
      run_prog(1, 0, n);
      check("halt_done", done, 1);
      check("halt_addr", addr, 17);
      check("halt_ctrl", ctrl, 0);
      check("halt_cycles", cycles, 18);
      check("halt_err", err, 0);

      // taken branch 3 -> 12, then sequential
      run_prog(2, 0, n);
      for (int i = 0; i < 10; i++) check("br1_trace", trace[i], (i < 4) ? i : i + 8);
      check("br1_err", err, 1);
      check("br1_cycles", cycles, 10);

      // taken branches 3 -> 12 -> 14
      run_prog(3, 0, n);
      for (int i = 0; i < 9; i++) check("br2_trace", trace[i], (i < 4) ? i : (i == 4) ? 12 : i + 9);
      check("br2_cycles", cycles, 9);

      // loop-back 11 -> 3, then 8 -> 10, then halt at 17
      run_prog(4, 0, n);
      check("loop_back", trace[12], 3);
      check("loop_skip", trace[18], 10);
      check("loop_done", done, 1);
      check("loop_cycles", cycles, 26);

      // start held through the run, then restart from DONE
      run_prog(1, 1, n);
      for (int i = 0; i < 18; i++) check("hold_trace", trace[i], i);
      check("hold_done", done, 1);
      check("hold_cycles", cycles, 18);
      @(posedge clk); #1;
      check("hold_stay", done, 1);
      start = 1;
      @(posedge clk); #1;
      start = 0;
      check("rs_addr", addr, 0);
      check("rs_busy", busy, 1);
      check("rs_cycles", cycles, 0);
      check("rs_done", done, 0);
      finish_run(1, 0, n);
      check("rs_halt", addr, 17);

      // long loop: counter saturates
      run_prog(5, 0, n);
      check("sat_done", done, 1);
      check("sat_cycles", cycles, 255);

      // randomized phase with random ROM contents, starts, flags and resets
      for (int i = 0; i < 3000; i++) begin
         if (i % 500 == 0) begin
            for (int k = 0; k < 18; k++)
               rom[k] = mk($urandom_range(0, 7), $urandom_range(0, 19), $urandom);
         end
         start = ($urandom_range(0, 7) == 0);
         cond  = 7'($urandom);
         if ($urandom_range(0, 99) == 0) begin
            reset = 1;
            #2 reset = 0;
         end
         @(posedge clk); #1;
      end

      cmp_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
